// File: rtl/smart_cargo_defs.sv
// Shared definitions for the cargo lift scheduler: FSM states, request layout
// and floor geometry.
package smart_cargo_defs;
  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = 2;
  localparam int ORG_LSB    = 0;
  localparam int DST_LSB    = 2;
  localparam int OBJ_LSB    = 4;
  localparam int REQ_W      = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_MOVE_ORG,
    ST_LOAD,
    ST_MOVE_DST,
    ST_UNLOAD,
    ST_HALT
  } state_t;

  // Packed so that the struct bits line up with req_data[5:0].
  typedef struct packed {
    logic [FLOOR_W-1:0] obj;
    logic [FLOOR_W-1:0] dst;
    logic [FLOOR_W-1:0] org;
  } req_t;
endpackage

// File: rtl/cargo_req_fifo.sv
// Synchronous request FIFO; pointers wrap naturally because DEPTH is a power of 2.
module cargo_req_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/cargo_trip_scheduler.sv
// Cargo lift trip scheduler: queues requests, then serves origin -> load ->
// destination -> unload, halting on emergency or inconsistent floor sensors.
//
//   state    | meaning
//   IDLE     | no trip; waits for a queued request
//   FETCH    | pop head request, aim at its origin
//   MOVE_ORG | drive towards origin floor
//   LOAD     | door dwell at origin
//   MOVE_DST | drive towards destination floor
//   UNLOAD   | door dwell at destination, then pulse delivered
//   HALT     | stopped by emergencia / sensor fault, resumes saved state
module cargo_trip_scheduler
  import smart_cargo_defs::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int DOOR_CYCLES = 1_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic [7:0]                    req_data,
  output logic                          req_ready,
  input  logic [3:0]                    sensores_n,
  input  logic                          emergencia,
  output logic                          motor_up,
  output logic                          motor_down,
  output logic [1:0]                    current_floor,
  output logic [1:0]                    target_floor,
  output logic [1:0]                    cur_object,
  output logic                          busy,
  output logic                          delivered,
  output logic                          sensor_fault,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);

  state_t               r_state, r_saved, w_next;
  logic [FLOOR_W-1:0]   r_cur, r_target, r_dst, r_obj;
  logic [DW-1:0]        r_door;
  logic                 r_motor_up, r_motor_down, r_delivered, r_sensor_fault;

  logic [3:0]           w_active;
  logic                 w_single, w_fault, w_stop, w_arrive, w_move;
  logic [FLOOR_W-1:0]   w_sensor_idx;
  logic                 w_push, w_pop, w_full, w_empty;
  logic                 w_door_load, w_to_dst, w_deliver;
  req_t                 w_head;
  logic                 w_unused_bits;

  assign w_unused_bits = ^req_data[7:REQ_W];

  assign w_active = ~sensores_n;
  always_comb begin
    w_single     = 1'b0;
    w_fault      = 1'b0;
    w_sensor_idx = '0;
    case (w_active)
      4'b0000: ;
      4'b0001: begin w_single = 1'b1; w_sensor_idx = 2'd0; end
      4'b0010: begin w_single = 1'b1; w_sensor_idx = 2'd1; end
      4'b0100: begin w_single = 1'b1; w_sensor_idx = 2'd2; end
      4'b1000: begin w_single = 1'b1; w_sensor_idx = 2'd3; end
      default: w_fault = 1'b1;
    endcase
  end

  assign w_stop   = emergencia || w_fault;
  assign w_arrive = w_single && (w_sensor_idx == r_target);

  // Same-floor requests are acknowledged but never queued.
  assign req_ready = !w_full;
  assign w_push    = req_valid && req_ready &&
                     (req_data[ORG_LSB +: FLOOR_W] != req_data[DST_LSB +: FLOOR_W]);

  cargo_req_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (req_data[REQ_W-1:0]),
    .o_data  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    w_door_load = 1'b0;
    w_to_dst    = 1'b0;
    w_deliver   = 1'b0;
    if (r_state != ST_IDLE && r_state != ST_HALT && w_stop) begin
      w_next = ST_HALT;
    end else begin
      case (r_state)
        ST_IDLE:     if (!w_empty && !w_stop) w_next = ST_FETCH;
        ST_FETCH:    begin w_pop = 1'b1; w_next = ST_MOVE_ORG; end
        ST_MOVE_ORG: if (w_arrive) begin w_next = ST_LOAD; w_door_load = 1'b1; end
        ST_LOAD:     if (r_door == '0) begin w_next = ST_MOVE_DST; w_to_dst = 1'b1; end
        ST_MOVE_DST: if (w_arrive) begin w_next = ST_UNLOAD; w_door_load = 1'b1; end
        ST_UNLOAD:   if (r_door == '0) begin w_next = ST_IDLE; w_deliver = 1'b1; end
        // Reloading the door counter on exit restarts an interrupted dwell.
        ST_HALT:     if (!w_stop) begin w_next = r_saved; w_door_load = 1'b1; end
        default:     w_next = ST_IDLE;
      endcase
    end
  end

  assign w_move = ((r_state == ST_MOVE_ORG) || (r_state == ST_MOVE_DST)) && (w_next == r_state);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_saved        <= ST_IDLE;
      r_cur          <= '0;
      r_target       <= '0;
      r_dst          <= '0;
      r_obj          <= '0;
      r_door         <= '0;
      r_motor_up     <= 1'b0;
      r_motor_down   <= 1'b0;
      r_delivered    <= 1'b0;
      r_sensor_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state != ST_HALT && w_next == ST_HALT) r_saved <= r_state;
      if (w_single) r_cur <= w_sensor_idx;
      r_sensor_fault <= w_fault;
      if (w_pop) begin
        r_target <= w_head.org;
        r_dst    <= w_head.dst;
        r_obj    <= w_head.obj;
      end else if (w_to_dst) begin
        r_target <= r_dst;
      end
      if (w_door_load)         r_door <= DOOR_LAST;
      else if (r_door != '0)   r_door <= r_door - 1'b1;
      r_motor_up   <= w_move && (r_target > r_cur);
      r_motor_down <= w_move && (r_target < r_cur);
      r_delivered  <= w_deliver;
    end
  end

  assign motor_up      = r_motor_up;
  assign motor_down    = r_motor_down;
  assign current_floor = r_cur;
  assign target_floor  = r_target;
  assign cur_object    = r_obj;
  assign busy          = (r_state != ST_IDLE);
  assign delivered     = r_delivered;
  assign sensor_fault  = r_sensor_fault;
endmodule
